// File: rtl/multu_datapath_pkg.sv
// multu_datapath_pkg: operand width and add/shift phase encoding shared by the multiply datapath
package multu_datapath_pkg;
  localparam int MULTU_W = 32;
  typedef enum logic {A_S_ADD = 1'b0, A_S_SHIFT = 1'b1} a_s_e;
endpackage

// File: rtl/multu_acc_adder.sv
// multu_acc_adder: W-bit + W-bit accumulator adder with carry-out (a, b -> sum, carry)
module multu_acc_adder
  import multu_datapath_pkg::*;
#(
  parameter int W = MULTU_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);
  assign {carry, sum} = a + b;
endmodule

// File: rtl/multu_datapath.sv
// multu_datapath: shift-add unsigned multiply datapath (load/step/a_s/add0 drive prod; done/result_ack handshake hi/lo/result_valid/overrun; prod_lsb feeds control)
module multu_datapath
  import multu_datapath_pkg::*;
#(
  parameter int WIDTH = MULTU_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             step,
  input  logic             a_s,
  input  logic             add0,
  input  logic             done,
  input  logic             result_ack,
  output logic             prod_lsb,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             result_valid,
  output logic             overrun
);
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic               carry;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  multu_acc_adder #(.W(WIDTH)) u_add (
    .a    (prod[2*WIDTH-1:WIDTH]),
    .b    (add0 ? '0 : mcand),
    .sum  (sum),
    .carry(cout)
  );
  assign prod_lsb = prod[0];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mcand        <= '0;
      prod         <= '0;
      carry        <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (load) begin
        mcand <= op_a;
        prod  <= {{WIDTH{1'b0}}, op_b};
        carry <= 1'b0;
      end else if (step && a_s_e'(a_s) == A_S_SHIFT) begin
        prod  <= {carry, prod[2*WIDTH-1:1]};
        carry <= 1'b0;
      end else if (step) begin
        prod[2*WIDTH-1:WIDTH] <= sum;
        carry                 <= cout;
      end
      if (done) begin
        hi           <= prod[2*WIDTH-1:WIDTH];
        lo           <= prod[WIDTH-1:0];
        result_valid <= 1'b1;
        overrun      <= overrun | (result_valid & ~result_ack);
      end else if (result_ack) begin
        result_valid <= 1'b0;
      end
    end
  end
endmodule
